// File: rtl/instruction_fetch_unit.sv
// Holds the PC and the IF/ID register; an instruction at PC reaches IF/ID one edge later.
// ID_stall freezes PC and IF/ID; an ID redirect squashes the wrong-path fetch into a one-cycle bubble.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 10,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               ID_stall,
   input  logic               ID_PCSrc,
   input  logic [31:0]        ID_new_PC,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_data,
   output logic [31:0]        PC,
   output logic [31:0]        IF_ID_Instruction,
   output logic [31:0]        IF_ID_PC4,
   output logic               IF_ID_valid,
   output logic [CNT_W-1:0]   cycle_count,
   output logic [CNT_W-1:0]   stall_count,
   output logic [CNT_W-1:0]   flush_count
);

   localparam logic [31:0] WORD_MASK = ~32'h0000_0003;

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      instr_q, instr_d;
   logic [31:0]      pc4_q, pc4_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic [31:0]      pc_plus4;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign pc_plus4  = pc_q + 32'd4;
   assign imem_addr = pc_q[IMEM_AW+1:2];

   // Stall outranks redirect: decode operands are stale while it is stalled.
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      cyc_d   = sat_inc(cyc_q);
      stall_d = stall_q;
      flush_d = flush_q;
      if (ID_stall) begin
         stall_d = sat_inc(stall_q);
      end else if (ID_PCSrc) begin
         pc_d    = ID_new_PC & WORD_MASK;
         instr_d = NOP_WORD;
         pc4_d   = 32'd0;
         valid_d = 1'b0;
         flush_d = sat_inc(flush_q);
      end else begin
         instr_d = imem_data;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
         pc_d    = pc_plus4;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         pc_q    <= RESET_PC & WORD_MASK;
         instr_q <= NOP_WORD;
         pc4_q   <= 32'd0;
         valid_q <= 1'b0;
         cyc_q   <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         cyc_q   <= cyc_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign PC                = pc_q;
   assign IF_ID_Instruction = instr_q;
   assign IF_ID_PC4         = pc4_q;
   assign IF_ID_valid       = valid_q;
   assign cycle_count       = cyc_q;
   assign stall_count       = stall_q;
   assign flush_count       = flush_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: expected IF/ID state is queued per edge and checked by a monitor.
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic [31:0] pc;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        ID_stall = 1'b0;
   logic        ID_PCSrc = 1'b0;
   logic [31:0] ID_new_PC = 32'd0;
   logic [9:0]  imem_addr, sat_addr;
   logic [31:0] imem_data, sat_data;
   logic [31:0] PC, IF_ID_Instruction, IF_ID_PC4;
   logic        IF_ID_valid;
   logic [31:0] cycle_count, stall_count, flush_count;
   logic [31:0] sat_pc, sat_instr, sat_pc4;
   logic        sat_valid;
   logic [3:0]  sat_cyc, sat_stall, sat_flush;

   logic [31:0] mem [1024];
   exp_t        exp_q[$];
   int          n_vec = 0;
   int          n_bad = 0;

   always #5 Clk = ~Clk;

   assign imem_data = mem[imem_addr];
   assign sat_data  = mem[sat_addr];

   instruction_fetch_unit dut (
      .Clk(Clk), .Rst(Rst), .ID_stall(ID_stall), .ID_PCSrc(ID_PCSrc), .ID_new_PC(ID_new_PC),
      .imem_addr(imem_addr), .imem_data(imem_data), .PC(PC),
      .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PC4(IF_ID_PC4), .IF_ID_valid(IF_ID_valid),
      .cycle_count(cycle_count), .stall_count(stall_count), .flush_count(flush_count)
   );

   instruction_fetch_unit #(.CNT_W(4)) u_sat (
      .Clk(Clk), .Rst(Rst), .ID_stall(ID_stall), .ID_PCSrc(ID_PCSrc), .ID_new_PC(ID_new_PC),
      .imem_addr(sat_addr), .imem_data(sat_data), .PC(sat_pc),
      .IF_ID_Instruction(sat_instr), .IF_ID_PC4(sat_pc4), .IF_ID_valid(sat_valid),
      .cycle_count(sat_cyc), .stall_count(sat_stall), .flush_count(sat_flush)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %08h, expected %08h at %0t", name, act, req, $time);
      end
   endtask

   // Called at a falling edge: drive inputs for the next rising edge, queue the expected result.
   task automatic step(input logic st, input logic src, input logic [31:0] npc,
                       input logic [31:0] e_instr, input logic [31:0] e_pc4,
                       input logic e_valid, input logic [31:0] e_pc);
      exp_t e;
      ID_stall  = st;
      ID_PCSrc  = src;
      ID_new_PC = npc;
      e.instr = e_instr; e.pc4 = e_pc4; e.valid = e_valid; e.pc = e_pc;
      exp_q.push_back(e);
      @(negedge Clk);
   endtask

   task automatic do_reset(input bit chk);
      Rst = 1'b0;
      #1;
      if (chk) begin
         check("rst_pc", PC, 32'h0);
         check("rst_instr", IF_ID_Instruction, NOP);
         check("rst_pc4", IF_ID_PC4, 32'h0);
         check("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
         check("rst_cycle", cycle_count, 32'd0);
         check("rst_stall", stall_count, 32'd0);
         check("rst_flush", flush_count, 32'd0);
      end
      @(negedge Clk);
      ID_stall = 1'b0; ID_PCSrc = 1'b0; ID_new_PC = 32'd0;
      Rst = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("if_id_instr", IF_ID_Instruction, e.instr);
            check("if_id_pc4", IF_ID_PC4, e.pc4);
            check("if_id_valid", {31'd0, IF_ID_valid}, {31'd0, e.valid});
            check("pc", PC, e.pc);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not reach the end, expected completion");
      $fatal(1);
   end

   initial begin : stim
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;
      @(negedge Clk);
      do_reset(1'b1);

      // free-running fetch of A,B,C,D
      step(0, 0, 0, 32'hC0DE_0000, 32'd4,  1, 32'd4);
      step(0, 0, 0, 32'hC0DE_0001, 32'd8,  1, 32'd8);
      step(0, 0, 0, 32'hC0DE_0002, 32'd12, 1, 32'd12);
      step(0, 0, 0, 32'hC0DE_0003, 32'd16, 1, 32'd16);
      check("cycle_count_4", cycle_count, 32'd4);

      // hazard stall holding B
      do_reset(1'b0);
      step(0, 0, 0, 32'hC0DE_0000, 32'd4, 1, 32'd4);
      step(0, 0, 0, 32'hC0DE_0001, 32'd8, 1, 32'd8);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 32'hC0DE_0001, 32'd8, 1, 32'd8);
      check("stall_count_3", stall_count, 32'd3);
      step(0, 0, 0, 32'hC0DE_0002, 32'd12, 1, 32'd12);

      // redirect to 0x40: one bubble then imem[16]
      step(0, 1, 32'h40, NOP, 32'd0, 0, 32'h40);
      check("flush_count_1", flush_count, 32'd1);
      step(0, 0, 0, 32'hC0DE_0010, 32'h44, 1, 32'h44);

      // stall masks a simultaneous redirect
      step(1, 1, 32'h80, 32'hC0DE_0010, 32'h44, 1, 32'h44);
      check("flush_masked", flush_count, 32'd1);
      check("stall_count_4", stall_count, 32'd4);
      step(0, 1, 32'h80, NOP, 32'd0, 0, 32'h80);
      check("flush_count_2", flush_count, 32'd2);
      step(0, 0, 0, 32'hC0DE_0020, 32'h84, 1, 32'h84);

      // unaligned target, then async reset right after the redirect
      step(0, 1, 32'h4B, NOP, 32'd0, 0, 32'h48);
      check("align_pc", PC, 32'h48);
      check("align_imem_addr", {22'd0, imem_addr}, 32'h12);
      do_reset(1'b1);

      step(0, 0, 0, 32'hC0DE_0000, 32'd4, 1, 32'd4);
      // back-to-back redirects are each honoured
      step(0, 1, 32'h10, NOP, 32'd0, 0, 32'h10);
      step(0, 1, 32'h20, NOP, 32'd0, 0, 32'h20);
      step(0, 0, 0, 32'hC0DE_0008, 32'h24, 1, 32'h24);
      check("flush_b2b", flush_count, 32'd2);
      // redirect to the current PC refetches it after a bubble
      step(0, 1, 32'h24, NOP, 32'd0, 0, 32'h24);
      step(0, 0, 0, 32'hC0DE_0009, 32'h28, 1, 32'h28);
      // PC+4 wraps at 2^32; imem_addr wraps at 1024 words
      step(0, 1, 32'hFFFF_FFFC, NOP, 32'd0, 0, 32'hFFFF_FFFC);
      check("wrap_imem_addr", {22'd0, imem_addr}, 32'h3FF);
      step(0, 0, 0, 32'hC0DE_03FF, 32'd0, 1, 32'd0);
      for (int k = 0; k < 10; k++)
         step(0, 0, 0, 32'hC0DE_0000 | k, 32'(4 * (k + 1)), 1, 32'(4 * (k + 1)));

      check("cycle_count_18", cycle_count, 32'd18);
      check("flush_count_4", flush_count, 32'd4);
      check("sat_cycle", {28'd0, sat_cyc}, 32'hF);
      check("sat_flush", {28'd0, sat_flush}, 32'd4);
      @(negedge Clk);
      check("sat_cycle_hold", {28'd0, sat_cyc}, 32'hF);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
